// File: rtl/single_precision_divider.sv
// IEEE-754 single-precision divider: Result = operand1 / operand2, radix-2 restoring, multi-cycle.
// Define ROUND_NEAREST_EN for round-to-nearest-even; otherwise the quotient is truncated toward zero.
module single_precision_divider #(
    parameter int EXP_BIAS = 127,
    parameter int Q_BITS   = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic        busy,
    output logic        done,
    output logic [31:0] Result,
    output logic [3:0]  Flags
);
    // state  | meaning
    // IDLE   | waiting for start; operands latched on accept
    // UNPACK | classify operands, seed remainder, exponent and counter
    // DIVIDE | one quotient bit per cycle, Q_BITS cycles
    // NORM   | align quotient to 1.x, extract G/R/sticky
    // ROUND  | round, range-check, select special result
    // DONE   | Result/Flags valid, done pulse
    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_DIVIDE, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         op1_q, op1_d, op2_q, op2_d;
    logic [24:0]         rem_q, rem_d;
    logic [Q_BITS-1:0]   quo_q, quo_d;
    logic [4:0]          cnt_q, cnt_d;
    logic signed [9:0]   er_q, er_d;
    logic [22:0]         frac_q, frac_d;
    logic                g_q, g_d, r_q, r_d, st_q, st_d;
    logic                spec_q, spec_d;
    logic [31:0]         sres_q, sres_d, result_q, result_d;
    logic [3:0]          sflg_q, sflg_d, flags_q, flags_d;

    logic [7:0]          e1, e2;
    logic                sign, z1, z2, ge, inc, carry, inexact;
    logic [23:0]         m2;
    logic [24:0]         diff;
    logic [22:0]         frac_r;
    logic signed [9:0]   er_r;

    assign e1      = op1_q[30:23];
    assign e2      = op2_q[30:23];
    assign z1      = (e1 == 8'h00);
    assign z2      = (e2 == 8'h00);
    assign sign    = op1_q[31] ^ op2_q[31];
    assign m2      = {1'b1, op2_q[22:0]};
    assign ge      = (rem_q >= {1'b0, m2});
    assign diff    = rem_q - {1'b0, m2};
    assign inexact = g_q | r_q | st_q;

`ifdef ROUND_NEAREST_EN
    assign inc = g_q & (r_q | st_q | frac_q[0]);
`else
    assign inc = 1'b0;
`endif

    // Hidden bit is always 1 after NORM, so a carry only happens from an all-ones fraction.
    assign carry  = inc & (&frac_q);
    assign frac_r = frac_q + {22'd0, inc};
    assign er_r   = carry ? (er_q + 10'sd1) : er_q;

    always_comb begin
        state_d  = state_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        er_d     = er_q;
        frac_d   = frac_q;
        g_d      = g_q;
        r_d      = r_q;
        st_d     = st_q;
        spec_d   = spec_q;
        sres_d   = sres_q;
        sflg_d   = sflg_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op1_d   = operand1;
                    op2_d   = operand2;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                spec_d = 1'b1;
                if (e1 == 8'hFF || e2 == 8'hFF || (z1 && z2)) begin
                    sres_d = 32'hFFFF_FFFF;
                    sflg_d = 4'b1000;
                end else if (z2) begin
                    sres_d = {sign, 8'hFF, 23'd0};
                    sflg_d = 4'b0100;
                end else if (z1) begin
                    sres_d = {sign, 31'd0};
                    sflg_d = 4'b0000;
                end else begin
                    spec_d = 1'b0;
                end
                rem_d   = {2'b01, op1_q[22:0]};
                quo_d   = '0;
                cnt_d   = 5'(Q_BITS - 1);
                er_d    = 10'({2'b00, e1}) - 10'({2'b00, e2}) + 10'(EXP_BIAS);
                // Specials skip the divide but still pass through ROUND to pick their result.
                state_d = spec_d ? S_ROUND : S_DIVIDE;
            end
            S_DIVIDE: begin
                quo_d = {quo_q[Q_BITS-2:0], ge};
                rem_d = ge ? (diff << 1) : (rem_q << 1);
                if (cnt_q == 5'd0) state_d = S_NORM;
                else               cnt_d   = cnt_q - 5'd1;
            end
            S_NORM: begin
                if (quo_q[26]) begin
                    frac_d = quo_q[25:3];
                    g_d    = quo_q[2];
                    r_d    = quo_q[1];
                    st_d   = quo_q[0] | (|rem_q);
                end else begin
                    frac_d = quo_q[24:2];
                    g_d    = quo_q[1];
                    r_d    = quo_q[0];
                    st_d   = |rem_q;
                    er_d   = er_q - 10'sd1;
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (spec_q) begin
                    result_d = sres_q;
                    flags_d  = sflg_q;
                end else if (er_r >= 10'sd255) begin
                    result_d = {sign, 8'hFF, 23'd0};
                    flags_d  = 4'b0101;
                end else if (er_r <= 10'sd0) begin
                    result_d = {sign, 31'd0};
                    flags_d  = 4'b0011;
                end else begin
                    result_d = {sign, er_r[7:0], frac_r};
                    flags_d  = {3'b000, inexact};
                end
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op1_q    <= '0;
            op2_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            er_q     <= '0;
            frac_q   <= '0;
            g_q      <= 1'b0;
            r_q      <= 1'b0;
            st_q     <= 1'b0;
            spec_q   <= 1'b0;
            sres_q   <= '0;
            sflg_q   <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            er_q     <= er_d;
            frac_q   <= frac_d;
            g_q      <= g_d;
            r_q      <= r_d;
            st_q     <= st_d;
            spec_q   <= spec_d;
            sres_q   <= sres_d;
            sflg_q   <= sflg_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done   = (state_q == S_DONE);
    assign Result = result_q;
    assign Flags  = flags_q;

endmodule

// File: tb/tb_single_precision_divider.sv
// Bench for single_precision_divider: exact-arithmetic reference model, directed and random operands.
module tb_single_precision_divider;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] operand1 = '0;
    logic [31:0] operand2 = '0;
    logic        busy, done;
    logic [31:0] Result;
    logic [3:0]  Flags;

    single_precision_divider dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .operand1(operand1), .operand2(operand2),
        .busy(busy), .done(done), .Result(Result), .Flags(Flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        expq[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          done_seen = 0;
    logic [31:0] prev_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Exact quotient via integer division; returns {Flags, Result}.
    function automatic logic [35:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic              s;
        int                ea, eb, e, k;
        longint unsigned   ma, mb, num, q, rm, mant;
        logic              g, r, st, inx;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255 || (ea == 0 && eb == 0)) return {4'b1000, 32'hFFFF_FFFF};
        if (eb == 0) return {4'b0100, s, 8'hFF, 23'd0};
        if (ea == 0) return {4'b0000, s, 31'd0};
        ma = longint'({1'b1, a[22:0]});
        mb = longint'({1'b1, b[22:0]});
        e  = ea - eb + 127;
        k  = 0;
        if (ma < mb) begin
            k = 1;
            e = e - 1;
        end
        num  = ma << (25 + k);
        q    = num / mb;
        rm   = num % mb;
        mant = q >> 2;
        g    = q[1];
        r    = q[0];
        st   = (rm != 0);
        inx  = g | r | st;
`ifdef ROUND_NEAREST_EN
        if (g && (r || st || mant[0])) mant = mant + 1;
        if (mant == (64'd1 << 24)) begin
            mant = 64'd1 << 23;
            e    = e + 1;
        end
`endif
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
        if (e <= 0)   return {4'b0011, s, 31'd0};
        return {3'b000, inx, s, e[7:0], mant[22:0]};
    endfunction

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
        if (a[30:23] == 8'h00 || a[30:23] == 8'hFF || b[30:23] == 8'h00 || b[30:23] == 8'hFF)
            return 3;
        return 31;
    endfunction

    function automatic logic [31:0] rnd_op();
        int          sel;
        logic [7:0]  e;
        logic [31:0] m;
        sel = $urandom_range(0, 99);
        if (sel < 6)       e = 8'h00;
        else if (sel < 11) e = 8'hFF;
        else if (sel < 30) e = 8'($urandom_range(1, 254));
        else               e = 8'($urandom_range(100, 154));
        m = $urandom;
        if ($urandom_range(0, 3) == 0) m[13:0] = '0;
        return {m[31], e, m[22:0]};
    endfunction

    // One compare process: every done cycle is scored; Result must hold otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_res = Result;
        end else begin
            if (done) begin
                done_seen++;
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 expected no pending operation (t=%0t)", $time);
                end else begin
                    mon_e = expq.pop_front();
                    check("result", 64'(Result), 64'(mon_e.res));
                    check("flags", 64'(Flags), 64'(mon_e.flg));
                    check("latency", 64'(cyc + 1 - mon_e.acc), 64'(mon_e.lat));
                    check("busy_in_done", 64'(busy), 64'd0);
                end
            end else begin
                check("result_hold", 64'(Result), 64'(prev_res));
            end
            prev_res = Result;
        end
    end

    // mode 0: plain; 1: extra start pulses at 5 and 20 cycles; 2: start held through done
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int mode);
        exp_t        e;
        logic [35:0] r;
        int          d0;
        int          k;
        r = ref_div(a, b);
        @(negedge clk);
        #1;
        operand1 = a;
        operand2 = b;
        start    = 1'b1;
        d0       = done_seen;
        @(negedge clk);
        e.res = r[31:0];
        e.flg = r[35:32];
        e.lat = exp_lat(a, b);
        e.acc = cyc;
        expq.push_back(e);
        check("busy_after_accept", 64'(busy), 64'd1);
        #1;
        if (mode != 2) start = 1'b0;
        operand1 = $urandom;
        operand2 = $urandom;
        k = 1;
        while (done_seen == d0 && k <= 60) begin
            if (mode == 1) start = (k == 5 || k == 20);
            @(negedge clk);
            #1;
            k++;
        end
        start = 1'b0;
        if (done_seen == d0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done expected done within 60 cycles (t=%0t)", $time);
            expq.delete();
        end
        if (mode != 0) begin
            d0 = done_seen;
            repeat (40) @(negedge clk);
            #1;
            check("no_extra_done", 64'(done_seen), 64'(d0));
            check("idle_after_ignored_start", 64'(busy), 64'd0);
        end
    endtask

    task automatic reset_mid_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        #1;
        operand1 = a;
        operand2 = b;
        start    = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(Result), 64'd0);
        check("rst_flags", 64'(Flags), 64'd0);
        expq.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] a, b;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(Result), 64'd0);
        check("reset_flags", 64'(Flags), 64'd0);
        #2;
        rst_n = 1'b1;

        check("model_6_div_2", 64'(ref_div(32'h40C00000, 32'h40000000)), 64'({4'b0000, 32'h40400000}));
`ifdef ROUND_NEAREST_EN
        check("model_1_div_3", 64'(ref_div(32'h3F800000, 32'h40400000)), 64'({4'b0001, 32'h3EAAAAAB}));
`else
        check("model_1_div_3", 64'(ref_div(32'h3F800000, 32'h40400000)), 64'({4'b0001, 32'h3EAAAAAA}));
`endif
        check("model_div0", 64'(ref_div(32'h3F800000, 32'h00000000)), 64'({4'b0100, 32'h7F800000}));
        check("model_0_div_0", 64'(ref_div(32'h00000000, 32'h00000000)), 64'({4'b1000, 32'hFFFFFFFF}));
        check("model_nan", 64'(ref_div(32'h7FC00000, 32'h3F800000)), 64'({4'b1000, 32'hFFFFFFFF}));
        check("model_ovf", 64'(ref_div(32'h7F7FFFFF, 32'h3E800000)), 64'({4'b0101, 32'h7F800000}));
        check("model_unf", 64'(ref_div(32'h00800000, 32'h4B000000)), 64'({4'b0011, 32'h00000000}));

        run_op(32'h40C00000, 32'h40000000, 0);
        run_op(32'h3F800000, 32'h40400000, 0);
        run_op(32'h3F800000, 32'h00000000, 0);
        run_op(32'h00000000, 32'h00000000, 0);
        run_op(32'h7FC00000, 32'h3F800000, 0);
        run_op(32'h7F7FFFFF, 32'h3E800000, 0);
        run_op(32'h00800000, 32'h4B000000, 0);
        run_op(32'h80000000, 32'h3F800000, 0);
        run_op(32'hC0C00000, 32'h40000000, 1);
        run_op(32'h40C00000, 32'hC0400000, 2);

        reset_mid_op(32'h3F800000, 32'h40400000);
        run_op(32'h3F800000, 32'h40400000, 0);

        for (int i = 0; i < 150; i++) begin
            a = rnd_op();
            b = rnd_op();
            if ($urandom_range(0, 7) == 0) b[22:0] = a[22:0];
            run_op(a, b, 0);
        end

        repeat (5) @(negedge clk);
        if (expq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL pending_at_end: got %0d pending expected 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
